np_pad_reader: RTL and testbench

Memory-mapped game-pad reader on the picosoc `iomem` bus, the first peripheral in the NinPortable SoC. It periodically scans a serial shift-register controller (latch/clock/data, 8 buttons), holds the debounced-by-frame button state in a register, and raises a level interrupt (wired to `irq_5`) when the state changes. It sits between the CPU's `iomem` port and the pad connector pins.

---
 rtl/np_pad_reader_if.sv | 35 +++
 rtl/np_pad_reader.sv | 240 ++++++++++++++++++++++++
 tb/tb_np_pad_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/np_pad_reader_if.sv
// np_pad_reader_if: picosoc iomem bus bundle between the CPU and the pad reader.
//
// Signals:
//   iomem_valid  master->slave  bus request
//   iomem_ready  slave->master  one-cycle acknowledge
//   iomem_wstrb  master->slave  byte write strobes, 0 = read
//   iomem_addr   master->slave  byte address
//   iomem_wdata  master->slave  write data
//   iomem_rdata  slave->master  read data, valid with iomem_ready
interface np_pad_reader_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/np_pad_reader.sv
// np_pad_reader: memory-mapped game-pad reader for the NinPortable SoC.
//
// Periodically scans an 8-button serial shift-register pad (latch / clock / data),
// keeps the last completed frame as the button state and raises a level interrupt
// when a frame differs from the previous one.
//
// Register window (16 bytes at BASE_ADDR):
//   0x0 STATUS     RO  [7:0] buttons (1 = pressed), [8] valid, [9] pending
//   0x4 CTRL       RW  [0] enable, [1] irq_en
//   0x8 CLEAR      WO  any write clears pending, reads 0
//   0xC SCAN_COUNT RO  [15:0] completed frames (wrapping)
//
// Ports:
//   CLK        core clock, rising edge
//   RST        synchronous active-low reset
//   bus        iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//   PAD_LATCH  pad latch, active high
//   PAD_CLK    pad shift clock
//   PAD_DATA   pad serial data, low = pressed, asynchronous
//   irq        level interrupt (pending & irq_en), registered
module np_pad_reader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
  parameter logic [15:0] HALF_PERIOD   = 16'd300,
  parameter logic [23:0] POLL_INTERVAL = 24'd200000
) (
  input  logic                  CLK,
  input  logic                  RST,
  np_pad_reader_if.slave        bus,
  output logic                  PAD_LATCH,
  output logic                  PAD_CLK,
  input  logic                  PAD_DATA,
  output logic                  irq
);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StShiftHi,
    StShiftLo,
    StDone
  } state_e;

  // Terminal counts for each phase; the counter always runs from 0.
  localparam logic [23:0] PollLast  = POLL_INTERVAL - 24'd1;
  localparam logic [23:0] LatchLast = {7'd0, HALF_PERIOD, 1'b0} - 24'd1;
  localparam logic [23:0] HalfLast  = {8'd0, HALF_PERIOD} - 24'd1;

  // Scan engine state
  state_e      state_q;
  logic [23:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  new_q;
  logic        latch_q;
  logic        pad_clk_q;

  // Pad data synchronizer
  logic        pad_meta_q;
  logic        pad_sync_q;

  // Software-visible registers
  logic        enable_q;
  logic        irq_en_q;
  logic        pending_q;
  logic        valid_q;
  logic [7:0]  buttons_q;
  logic [15:0] scan_count_q;
  logic        irq_q;

  // Bus response registers
  logic        ready_q;
  logic [31:0] rdata_q;

  // Bus decode
  logic        hit;
  logic        accept;
  logic        wr;
  logic [1:0]  reg_sel;
  logic        ctrl_wr;
  logic        clear_wr;
  logic [31:0] rdata_d;

  // Frame completion
  logic        done;
  logic        changed;

  logic        unused_bus_bits;

  assign hit      = (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
  // Gating on ready_q makes back-to-back requests complete every other cycle.
  assign accept   = bus.iomem_valid && hit && !ready_q;
  assign wr       = accept && (bus.iomem_wstrb != 4'd0);
  assign reg_sel  = bus.iomem_addr[3:2];
  assign ctrl_wr  = wr && (reg_sel == 2'd1);
  assign clear_wr = wr && (reg_sel == 2'd2);

  assign done     = (state_q == StDone);
  assign changed  = (new_q != buttons_q);

  assign unused_bus_bits = ^{bus.iomem_wdata[31:2], bus.iomem_addr[1:0]};

  always_comb begin
    rdata_d = 32'd0;
    case (reg_sel)
      2'd0:    rdata_d = {22'd0, pending_q, valid_q, buttons_q};
      2'd1:    rdata_d = {30'd0, irq_en_q, enable_q};
      2'd2:    rdata_d = 32'd0;
      default: rdata_d = {16'd0, scan_count_q};
    endcase
  end

  // Register file, bus response, synchronizer and interrupt.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ready_q      <= 1'b0;
      rdata_q      <= 32'd0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      pending_q    <= 1'b0;
      valid_q      <= 1'b0;
      buttons_q    <= 8'd0;
      scan_count_q <= 16'd0;
      irq_q        <= 1'b0;
      pad_meta_q   <= 1'b0;
      pad_sync_q   <= 1'b0;
    end else begin
      ready_q    <= accept;
      rdata_q    <= accept ? rdata_d : 32'd0;
      pad_meta_q <= PAD_DATA;
      pad_sync_q <= pad_meta_q;

      if (ctrl_wr) begin
        enable_q <= bus.iomem_wdata[0];
        irq_en_q <= bus.iomem_wdata[1];
      end

      if (done) begin
        buttons_q    <= new_q;
        valid_q      <= 1'b1;
        scan_count_q <= scan_count_q + 16'd1;
      end

      // A change detected on DONE takes priority over a simultaneous CLEAR.
      if (done && changed) begin
        pending_q <= 1'b1;
      end else if (clear_wr) begin
        pending_q <= 1'b0;
      end

      irq_q <= pending_q & irq_en_q;
    end
  end

  // Scan engine. Enable is only consulted in IDLE, so a frame in flight always
  // completes even if software disables the reader.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      cnt_q     <= 24'd0;
      idx_q     <= 3'd0;
      new_q     <= 8'd0;
      latch_q   <= 1'b0;
      pad_clk_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!enable_q) begin
            cnt_q <= 24'd0;
          end else if (cnt_q == PollLast) begin
            cnt_q   <= 24'd0;
            latch_q <= 1'b1;
            state_q <= StLatch;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        StLatch: begin
          if (cnt_q == LatchLast) begin
            // Bit 0 is on the data pin while the latch is high.
            cnt_q     <= 24'd0;
            new_q[0]  <= ~pad_sync_q;
            idx_q     <= 3'd1;
            latch_q   <= 1'b0;
            pad_clk_q <= 1'b1;
            state_q   <= StShiftHi;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        StShiftHi: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= 24'd0;
            pad_clk_q <= 1'b0;
            state_q   <= StShiftLo;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        StShiftLo: begin
          if (cnt_q == HalfLast) begin
            // Sample at the end of the low phase so the bit shifted on the
            // preceding rising edge has had a full period to cross the synchronizer.
            cnt_q        <= 24'd0;
            new_q[idx_q] <= ~pad_sync_q;
            if (idx_q == 3'd7) begin
              state_q <= StDone;
            end else begin
              idx_q     <= idx_q + 3'd1;
              pad_clk_q <= 1'b1;
              state_q   <= StShiftHi;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        StDone: begin
          cnt_q   <= 24'd0;
          state_q <= StIdle;
        end

        default: begin
          cnt_q     <= 24'd0;
          latch_q   <= 1'b0;
          pad_clk_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign PAD_LATCH       = latch_q;
  assign PAD_CLK         = pad_clk_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_np_pad_reader.sv
// Bench for np_pad_reader: register access table, scan timing, clear/collision,
// disable and mid-frame reset, with a scoreboard queue for bus read data.
module tb_np_pad_reader;

  localparam logic [31:0] Base = 32'h0300_0000;

  logic CLK = 1'b0;
  logic RST;
  logic PAD_LATCH;
  logic PAD_CLK;
  logic PAD_DATA;
  logic irq;

  np_pad_reader_if bus_if ();

  np_pad_reader #(
    .BASE_ADDR    (Base),
    .HALF_PERIOD  (16'd4),
    .POLL_INTERVAL(24'd100)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if),
    .PAD_LATCH(PAD_LATCH),
    .PAD_CLK  (PAD_CLK),
    .PAD_DATA (PAD_DATA),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pad model: latch captures the pattern, each PAD_CLK rise moves to the next bit.
  logic [7:0] pattern = 8'h00;
  logic [7:0] pad_pat = 8'h00;
  logic [3:0] pad_bit = 4'd0;
  always @(posedge PAD_LATCH or posedge PAD_CLK) begin
    if (PAD_CLK) begin
      pad_bit <= pad_bit + 4'd1;
    end else begin
      pad_bit <= 4'd0;
      pad_pat <= pattern;
    end
  end
  assign PAD_DATA = (pad_bit < 4'd8) ? ~pad_pat[pad_bit[2:0]] : 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned acc_cyc;
  int unsigned latch_cyc;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one request at the current time; read expectations go through the scoreboard.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [31:0] exp, input string name);
    int  lat;
    bit  got;
    bit  is_rd;
    sb_t e;
    is_rd = (wstrb == 4'd0);
    if (is_rd) sb_q.push_back('{name: name, exp: exp});
    bus_if.iomem_addr  = addr;
    bus_if.iomem_wstrb = wstrb;
    bus_if.iomem_wdata = wdata;
    bus_if.iomem_valid = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus_if.iomem_ready) got = 1'b1;
    end
    acc_cyc = cyc;
    check({name, "_lat"}, lat, 1);
    if (is_rd) begin
      e = sb_q.pop_front();
      check(e.name, bus_if.iomem_rdata, e.exp);
    end
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'd0;
    @(posedge CLK);
    #1;
    check({name, "_drop"}, (bus_if.iomem_ready || bus_if.iomem_rdata != 32'd0) ? 1 : 0, 0);
  endtask

  task automatic wait_latch(input string name);
    int n;
    n = 0;
    while (!PAD_LATCH && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    latch_cyc = cyc;
    check({name, "_latch_seen"}, PAD_LATCH, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int bad_l;
    int bad_c;
    int pulses;
    int bad;
    logic prev_clk;
    logic exp_l;
    logic exp_c;

    vecs[0]  = '{addr: Base + 0,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "rst_status"};
    vecs[1]  = '{addr: Base + 4,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "rst_ctrl"};
    vecs[2]  = '{addr: Base + 8,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "rd_clear"};
    vecs[3]  = '{addr: Base + 12, wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "rst_scan"};
    vecs[4]  = '{addr: Base + 4,  wstrb: 4'hF, wdata: 32'hFFFF_FFFC, exp: 32'h0, name: "wr_hi"};
    vecs[5]  = '{addr: Base + 4,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "ctrl_mask"};
    vecs[6]  = '{addr: Base + 4,  wstrb: 4'h8, wdata: 32'h2,         exp: 32'h0, name: "wr_strb"};
    vecs[7]  = '{addr: Base + 4,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h2, name: "ctrl_strb"};
    vecs[8]  = '{addr: Base + 4,  wstrb: 4'hF, wdata: 32'h3,         exp: 32'h0, name: "wr_ctrl3"};
    vecs[9]  = '{addr: Base + 4,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h3, name: "ctrl_rw"};
    vecs[10] = '{addr: Base + 4,  wstrb: 4'hF, wdata: 32'h0,         exp: 32'h0, name: "wr_ctrl0"};
    vecs[11] = '{addr: Base + 0,  wstrb: 4'hF, wdata: 32'h3FF,       exp: 32'h0, name: "wr_status"};
    vecs[12] = '{addr: Base + 0,  wstrb: 4'h0, wdata: 32'h0,         exp: 32'h0, name: "status_ro"};

    RST = 1'b0;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'd0;
    bus_if.iomem_addr  = 32'd0;
    bus_if.iomem_wdata = 32'd0;
    step(3);
    check("rst_outputs", {27'd0, bus_if.iomem_ready, |bus_if.iomem_rdata, PAD_LATCH, PAD_CLK, irq},
          32'd0);
    RST = 1'b1;
    step(1);

    foreach (vecs[i]) bus_xfer(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].exp,
                               vecs[i].name);

    // Address miss: never acknowledged, read data stays low.
    bus_if.iomem_addr  = 32'h0400_0000;
    bus_if.iomem_wstrb = 4'd0;
    bus_if.iomem_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus_if.iomem_ready || bus_if.iomem_rdata != 32'd0) bad++;
    end
    bus_if.iomem_valid = 1'b0;
    check("miss_noready", bad, 0);

    // First scan of 0xA5.
    pattern = 8'hA5;
    bus_xfer(Base + 4, 4'hF, 32'h3, 32'h0, "en_ctrl");
    begin
      int unsigned wr_cyc;
      wr_cyc = acc_cyc;
      wait_latch("frame1");
      check("latch_delay", latch_cyc - wr_cyc, 100);
    end
    bad_l = 0;
    bad_c = 0;
    pulses = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 80; i++) begin
      exp_l = (i < 8);
      exp_c = (i >= 8) && (i < 64) && (((i - 8) % 8) < 4);
      if (PAD_LATCH !== exp_l) bad_l++;
      if (PAD_CLK !== exp_c) bad_c++;
      if (PAD_CLK && !prev_clk) pulses++;
      prev_clk = PAD_CLK;
      step(1);
    end
    check("latch_wave", bad_l, 0);
    check("clk_wave", bad_c, 0);
    check("clk_pulses", pulses, 7);
    bus_xfer(Base + 0, 4'h0, 32'h0, 32'h3A5, "scan_status");
    check("scan_irq", irq, 1);
    bus_xfer(Base + 12, 4'h0, 32'h0, 32'h1, "scan_count1");

    // Clear, then an identical frame must not set pending.
    bus_xfer(Base + 8, 4'hF, 32'h1, 32'h0, "clear_wr");
    bus_xfer(Base + 0, 4'h0, 32'h0, 32'h1A5, "clear_status");
    check("clear_irq", irq, 0);
    wait_latch("frame2");
    step(70);
    bus_xfer(Base + 0, 4'h0, 32'h0, 32'h1A5, "repeat_status");
    bus_xfer(Base + 12, 4'h0, 32'h0, 32'h2, "scan_count2");
    check("repeat_irq", irq, 0);

    // Collision: CLEAR accepted on the DONE edge (frame-relative cycle 64).
    pattern = 8'h01;
    wait_latch("frame3");
    step(64);
    bus_xfer(Base + 8, 4'hF, 32'h1, 32'h0, "coll_clear");
    bus_xfer(Base + 0, 4'h0, 32'h0, 32'h301, "coll_status");
    check("coll_irq", irq, 1);
    bus_xfer(Base + 12, 4'h0, 32'h0, 32'h3, "scan_count3");

    // Disable during SHIFT_HI: frame still completes, then no further scans.
    wait_latch("frame4");
    step(10);
    check("dis_in_shift_hi", PAD_CLK, 1);
    bus_xfer(Base + 4, 4'hF, 32'h0, 32'h0, "dis_ctrl");
    step(70);
    bus_xfer(Base + 12, 4'h0, 32'h0, 32'h4, "dis_scan");
    check("dis_irq", irq, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (PAD_LATCH) bad++;
    end
    check("dis_no_latch", bad, 0);

    // Reset in the middle of a frame while PAD_CLK and irq are high.
    bus_xfer(Base + 4, 4'hF, 32'h3, 32'h0, "re_en");
    wait_latch("frame5");
    step(24);
    check("pre_rst_clk", PAD_CLK, 1);
    check("pre_rst_irq", irq, 1);
    RST = 1'b0;
    step(1);
    check("midrst_outputs",
          {27'd0, bus_if.iomem_ready, |bus_if.iomem_rdata, PAD_LATCH, PAD_CLK, irq}, 32'd0);
    step(2);
    RST = 1'b1;
    step(1);
    bus_xfer(Base + 0, 4'h0, 32'h0, 32'h0, "midrst_status");
    bus_xfer(Base + 4, 4'h0, 32'h0, 32'h0, "midrst_ctrl");
    bus_xfer(Base + 12, 4'h0, 32'h0, 32'h0, "midrst_scan");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
